// File: rtl/aes128_encrypt_core.sv
// Iterative AES-128 encryption: one full round per clock. Round keys are expanded
// on the fly alongside the state, and a start/done handshake goes to the controller.

module aes_sbox (
   input  logic [7:0] byte_val,
   output logic [7:0] sub_val
);
   // FIPS-197 forward S-box; entry 0 sits in the top byte of the table.
   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   assign sub_val = SBOX_TABLE[{~byte_val, 3'b000} +: 8];
endmodule

module aes128_encrypt_core (
   input  logic         clk,
   input  logic         n_rst,
   input  logic         start,
   input  logic [127:0] key_in,
   input  logic [127:0] data_in,
   output logic         busy,
   output logic         done,
   output logic [127:0] data_out,
   output logic [3:0]   round_num
);
   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} fsm_t;

   fsm_t         fsm_r;
   logic [127:0] state_r;
   logic [127:0] rk_r;
   logic [7:0]   sb_s [16];
   logic [127:0] sr_s;
   logic [127:0] mc_s;
   logic [31:0]  rot_s;
   logic [31:0]  sub_word_s;
   logic [7:0]   rcon_s;
   logic [31:0]  w4_s, w5_s, w6_s, w7_s;
   logic [127:0] next_rk_s;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] mix_col(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      a0 = col[31:24];
      a1 = col[23:16];
      a2 = col[15:8];
      a3 = col[7:0];
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   // Rcon is indexed by the round about to execute, which is exactly round_num.
   always_comb begin
      rcon_s = 8'h00;
      case (round_num)
         4'd1:    rcon_s = 8'h01;
         4'd2:    rcon_s = 8'h02;
         4'd3:    rcon_s = 8'h04;
         4'd4:    rcon_s = 8'h08;
         4'd5:    rcon_s = 8'h10;
         4'd6:    rcon_s = 8'h20;
         4'd7:    rcon_s = 8'h40;
         4'd8:    rcon_s = 8'h80;
         4'd9:    rcon_s = 8'h1b;
         4'd10:   rcon_s = 8'h36;
         default: rcon_s = 8'h00;
      endcase
   end

   genvar i, r, c;
   generate
      for (i = 0; i < 16; i++) begin : g_state_sbox
         aes_sbox u_sbox (.byte_val(state_r[127-8*i -: 8]), .sub_val(sb_s[i]));
      end
      // Byte index is row + 4*col; row r rotates left by r columns.
      for (r = 0; r < 4; r++) begin : g_row
         for (c = 0; c < 4; c++) begin : g_col
            assign sr_s[127-8*(r+4*c) -: 8] = sb_s[r + 4*((c + r) % 4)];
         end
      end
      for (c = 0; c < 4; c++) begin : g_mix
         assign mc_s[127-32*c -: 32] = mix_col(sr_s[127-32*c -: 32]);
      end
      for (i = 0; i < 4; i++) begin : g_key_sbox
         aes_sbox u_sbox (.byte_val(rot_s[31-8*i -: 8]), .sub_val(sub_word_s[31-8*i -: 8]));
      end
   endgenerate

   assign rot_s     = {rk_r[23:0], rk_r[31:24]};
   assign w4_s      = rk_r[127:96] ^ sub_word_s ^ {rcon_s, 24'h000000};
   assign w5_s      = rk_r[95:64] ^ w4_s;
   assign w6_s      = rk_r[63:32] ^ w5_s;
   assign w7_s      = rk_r[31:0]  ^ w6_s;
   assign next_rk_s = {w4_s, w5_s, w6_s, w7_s};

   // Round sequencer with registered handshake and result outputs.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         fsm_r     <= IDLE;
         state_r   <= 128'h0;
         rk_r      <= 128'h0;
         data_out  <= 128'h0;
         busy      <= 1'b0;
         done      <= 1'b0;
         round_num <= 4'd0;
      end else begin
         case (fsm_r)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state_r   <= data_in ^ key_in;
                  rk_r      <= key_in;
                  round_num <= 4'd1;
                  busy      <= 1'b1;
                  fsm_r     <= RUN;
               end else begin
                  round_num <= 4'd0;
                  busy      <= 1'b0;
               end
            end
            RUN: begin
               rk_r <= next_rk_s;
               if (round_num == 4'd10) begin
                  data_out  <= sr_s ^ next_rk_s;
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  round_num <= 4'd0;
                  fsm_r     <= IDLE;
               end else begin
                  state_r   <= mc_s ^ next_rk_s;
                  round_num <= round_num + 4'd1;
               end
            end
            default: begin
               fsm_r     <= IDLE;
               busy      <= 1'b0;
               done      <= 1'b0;
               round_num <= 4'd0;
            end
         endcase
      end
   end
endmodule
